// File: rtl/id_stage_if.sv
// id_stage_if: groups the fetch-side handshake, the register-file read port,
// the writeback bundle and the ID/EX output register of the decode stage.
// The decode stage connects through the slave modport. Its environment
// (fetch, reg_file, execute) connects through the master modport.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            wb_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [3:0]      out_alu_op;
    logic            out_alu_src_imm;
    logic            out_alu_src_pc;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_branch;
    logic            out_jump;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc,
        input  rs1_data, rs2_data,
        input  wb_write, wb_rd, wb_data,
        input  flush, out_ready,
        output in_ready, rs1, rs2,
        output out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
        output out_rd, out_funct3, out_alu_op,
        output out_alu_src_imm, out_alu_src_pc, out_reg_write,
        output out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc,
        output rs1_data, rs2_data,
        output wb_write, wb_rd, wb_data,
        output flush, out_ready,
        input  in_ready, rs1, rs2,
        input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
        input  out_rd, out_funct3, out_alu_op,
        input  out_alu_src_imm, out_alu_src_pc, out_reg_write,
        input  out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage. Drives register-file read
// addresses, decodes control fields and immediates, selects operands and
// latches everything into a valid/ready ID/EX register. Load-use hazards
// against the instruction held in ID/EX stall the input for one cycle.
// Optional feature macro: ID_BYPASS_EN enables the writeback bypass. When it
// is undefined, operands come straight from the register file and wb_* are
// ignored.
module id_stage #(
    parameter int XLEN = 32
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd_field;
    logic [2:0]      funct3;
    logic            funct7_b5;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    logic [XLEN-1:0] dec_imm;
    logic [3:0]      dec_alu_op;
    logic            dec_src_imm;
    logic            dec_src_pc;
    logic            dec_writes;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_branch;
    logic            dec_jump;
    logic            dec_illegal;
    logic            dec_lui;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            dec_reg_write;
    logic [4:0]      dec_rd;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic            hazard;
    logic            adv;
    logic            accept;

    assign instr     = bus.in_instr;
    assign opcode    = instr[6:0];
    assign rd_field  = instr[11:7];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

    // Read addresses go to reg_file in the same cycle the instruction is offered.
    assign bus.rs1 = instr[19:15];
    assign bus.rs2 = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode decode into control fields, immediate and register usage.
    always_comb begin
        dec_imm       = '0;
        dec_alu_op    = 4'b0000;
        dec_src_imm   = 1'b0;
        dec_src_pc    = 1'b0;
        dec_writes    = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        dec_lui       = 1'b0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        case (opcode)
            OP_R: begin
                dec_alu_op = {funct7_b5, funct3};
                dec_writes = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_IMM: begin
                dec_imm     = imm_i;
                dec_alu_op  = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
                dec_src_imm = 1'b1;
                dec_writes  = 1'b1;
                uses_rs1    = 1'b1;
            end
            OP_LOAD: begin
                dec_imm      = imm_i;
                dec_src_imm  = 1'b1;
                dec_writes   = 1'b1;
                dec_mem_read = 1'b1;
                uses_rs1     = 1'b1;
            end
            OP_STORE: begin
                dec_imm       = imm_s;
                dec_src_imm   = 1'b1;
                dec_mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm    = imm_b;
                dec_branch = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_JAL: begin
                dec_imm     = imm_j;
                dec_src_imm = 1'b1;
                dec_src_pc  = 1'b1;
                dec_writes  = 1'b1;
                dec_jump    = 1'b1;
            end
            OP_JALR: begin
                dec_imm     = imm_i;
                dec_src_imm = 1'b1;
                dec_writes  = 1'b1;
                dec_jump    = 1'b1;
                uses_rs1    = 1'b1;
            end
            OP_LUI: begin
                dec_imm     = imm_u;
                dec_src_imm = 1'b1;
                dec_writes  = 1'b1;
                dec_lui     = 1'b1;
            end
            OP_AUIPC: begin
                dec_imm     = imm_u;
                dec_src_imm = 1'b1;
                dec_src_pc  = 1'b1;
                dec_writes  = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Writes to x0 are dropped, and rd reads as 0 whenever nothing is written.
    assign dec_reg_write = dec_writes && (rd_field != 5'd0);
    assign dec_rd        = dec_reg_write ? rd_field : 5'd0;

`ifdef ID_BYPASS_EN
    // Operand select: x0 is zero, a same-cycle writeback wins over the array.
    always_comb begin
        rs1_val = bus.rs1_data;
        rs2_val = bus.rs2_data;
        if (bus.rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (bus.wb_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs1)) begin
            rs1_val = bus.wb_data;
        end
        if (bus.rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (bus.wb_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs2)) begin
            rs2_val = bus.wb_data;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_write, bus.wb_rd, bus.wb_data};

    // Operand select without bypass: x0 is zero, otherwise the array value.
    always_comb begin
        rs1_val = (bus.rs1 == 5'd0) ? '0 : bus.rs1_data;
        rs2_val = (bus.rs2 == 5'd0) ? '0 : bus.rs2_data;
    end
`endif

    // Load-use check against the load currently held in ID/EX, plus handshake.
    always_comb begin
        hazard = bus.out_valid && bus.out_mem_read && (bus.out_rd != 5'd0) &&
                 ((uses_rs1 && (bus.out_rd == bus.rs1)) ||
                  (uses_rs2 && (bus.out_rd == bus.rs2)));
        adv          = !bus.out_valid || bus.out_ready;
        bus.in_ready = adv && !hazard && !bus.flush && !rst;
        accept       = bus.in_valid && bus.in_ready;
    end

    // ID/EX register: flush kills, advance loads or bubbles, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid       <= 1'b0;
            bus.out_pc          <= '0;
            bus.out_rs1_val     <= '0;
            bus.out_rs2_val     <= '0;
            bus.out_imm         <= '0;
            bus.out_rd          <= '0;
            bus.out_funct3      <= '0;
            bus.out_alu_op      <= '0;
            bus.out_alu_src_imm <= 1'b0;
            bus.out_alu_src_pc  <= 1'b0;
            bus.out_reg_write   <= 1'b0;
            bus.out_mem_read    <= 1'b0;
            bus.out_mem_write   <= 1'b0;
            bus.out_branch      <= 1'b0;
            bus.out_jump        <= 1'b0;
            bus.out_illegal     <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (adv) begin
            if (accept) begin
                bus.out_valid       <= 1'b1;
                bus.out_pc          <= bus.in_pc;
                bus.out_rs1_val     <= dec_lui ? '0 : rs1_val;
                bus.out_rs2_val     <= rs2_val;
                bus.out_imm         <= dec_imm;
                bus.out_rd          <= dec_rd;
                bus.out_funct3      <= funct3;
                bus.out_alu_op      <= dec_alu_op;
                bus.out_alu_src_imm <= dec_src_imm;
                bus.out_alu_src_pc  <= dec_src_pc;
                bus.out_reg_write   <= dec_reg_write;
                bus.out_mem_read    <= dec_mem_read;
                bus.out_mem_write   <= dec_mem_write;
                bus.out_branch      <= dec_branch;
                bus.out_jump        <= dec_jump;
                bus.out_illegal     <= dec_illegal;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage. The stimulus side predicts
// in_ready from a small model of the ID/EX register and pushes the expected
// decode of every accepted instruction. The monitor pops and compares each
// time the DUT hands an entry to execute or has it flushed.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        srcImm;
        logic        srcPc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        ill;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic       mValid   = 1'b0;
    logic       mMemRead = 1'b0;
    logic [4:0] mRd      = 5'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operand value as the register file plus optional writeback forwarding sees it.
    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d,
                                            input logic wbw, input logic [4:0] wbrd,
                                            input logic [31:0] wbd);
        if (a == 0) return 32'd0;
        if (BYP && wbw && wbrd != 0 && wbrd == a) return wbd;
        return d;
    endfunction

    // Reference decode written from the ISA tables with plain arithmetic.
    function automatic exp_t refModel(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] d1, input logic [31:0] d2,
                                      input logic wbw, input logic [4:0] wbrd,
                                      input logic [31:0] wbd, output bit u1, output bit u2);
        exp_t e;
        logic [6:0] op = instr[6:0];
        logic [31:0] sx = instr[31] ? 32'hFFFF_FFFF : 32'h0;
        logic [31:0] immI, immS, immB, immU, immJ;
        bit isR, isI, isLd, isSt, isBr, isJal, isJalr, isLui, isAuipc, known;
        isR = (op == 7'h33); isI = (op == 7'h13); isLd = (op == 7'h03);
        isSt = (op == 7'h23); isBr = (op == 7'h63); isJal = (op == 7'h6F);
        isJalr = (op == 7'h67); isLui = (op == 7'h37); isAuipc = (op == 7'h17);
        known = isR | isI | isLd | isSt | isBr | isJal | isJalr | isLui | isAuipc;
        immI = (sx << 12) | (instr >> 20);
        immS = (sx << 12) | ((instr >> 25) << 5) | ((instr >> 7) & 32'h1F);
        immB = (sx << 12) | (((instr >> 7) & 32'h1) << 11) |
               (((instr >> 25) & 32'h3F) << 5) | (((instr >> 8) & 32'hF) << 1);
        immU = instr & 32'hFFFF_F000;
        immJ = (sx << 20) | (instr & 32'h000F_F000) | (((instr >> 20) & 32'h1) << 11) |
               (((instr >> 21) & 32'h3FF) << 1);
        e.pc = pc;
        e.f3 = instr[14:12];
        e.imm = (isI | isLd | isJalr) ? immI : isSt ? immS : isBr ? immB :
                (isLui | isAuipc) ? immU : isJal ? immJ : 32'd0;
        e.alu = isR ? {instr[30], instr[14:12]} :
                isI ? {(instr[14:12] == 3'd5) & instr[30], instr[14:12]} : 4'd0;
        e.srcImm = known && !isR && !isBr;
        e.srcPc = isAuipc | isJal;
        e.rw = (isR | isI | isLd | isJal | isJalr | isLui | isAuipc) && instr[11:7] != 0;
        e.rd = e.rw ? instr[11:7] : 5'd0;
        e.mr = isLd;
        e.mw = isSt;
        e.br = isBr;
        e.jp = isJal | isJalr;
        e.ill = !known;
        e.rs1v = isLui ? 32'd0 : operand(instr[19:15], d1, wbw, wbrd, wbd);
        e.rs2v = operand(instr[24:20], d2, wbw, wbrd, wbd);
        u1 = isR | isI | isLd | isSt | isBr | isJalr;
        u2 = isR | isSt | isBr;
        return e;
    endfunction

    // One cycle of stimulus, entered and left #1 after a rising edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                                 input logic inv, input logic ordy, input logic fl);
        exp_t e;
        bit u1, u2, hz, predReady, accept;
        bus.in_valid = inv; bus.in_instr = instr; bus.in_pc = pc;
        bus.rs1_data = d1; bus.rs2_data = d2;
        bus.wb_write = wbw; bus.wb_rd = wbrd; bus.wb_data = wbd;
        bus.out_ready = ordy; bus.flush = fl;
        #1;
        e = refModel(instr, pc, d1, d2, wbw, wbrd, wbd, u1, u2);
        hz = mValid && mMemRead && mRd != 0 &&
             ((u1 && mRd == instr[19:15]) || (u2 && mRd == instr[24:20]));
        predReady = (!mValid || ordy) && !hz && !fl;
        checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, predReady});
        checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, mValid});
        checkOutput("rs1_addr", {27'd0, bus.rs1}, {27'd0, instr[19:15]});
        checkOutput("rs2_addr", {27'd0, bus.rs2}, {27'd0, instr[24:20]});
        accept = inv && predReady;
        if (accept) sb.push_back(e);
        if (fl) begin
            mValid = 1'b0;
        end else if (!mValid || ordy) begin
            mValid = accept;
            if (accept) begin
                mMemRead = e.mr;
                mRd = e.rd;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(32'h0000_0013, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] genInstr();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        logic [6:0] op = ops[$urandom_range(0, 9)];
        logic [6:0] top = 7'($urandom);
        logic [4:0] a2 = 5'($urandom_range(0, 7));
        logic [4:0] a1 = 5'($urandom_range(0, 7));
        logic [2:0] f3 = 3'($urandom);
        logic [4:0] rd = 5'($urandom_range(0, 7));
        return {top, a2, a1, f3, rd, op};
    endfunction

    // Monitor: every entry leaving ID/EX (consumed or flushed) is compared.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && (bus.out_ready || bus.flush)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard_empty: got out_valid=1 expected no entry");
            end else begin
                e = sb.pop_front();
                checkOutput("out_pc", bus.out_pc, e.pc);
                checkOutput("out_rs1_val", bus.out_rs1_val, e.rs1v);
                checkOutput("out_rs2_val", bus.out_rs2_val, e.rs2v);
                checkOutput("out_imm", bus.out_imm, e.imm);
                checkOutput("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
                checkOutput("out_funct3", {29'd0, bus.out_funct3}, {29'd0, e.f3});
                checkOutput("out_alu_op", {28'd0, bus.out_alu_op}, {28'd0, e.alu});
                checkOutput("out_ctrl",
                    {24'd0, bus.out_alu_src_imm, bus.out_alu_src_pc, bus.out_reg_write,
                     bus.out_mem_read, bus.out_mem_write, bus.out_branch, bus.out_jump,
                     bus.out_illegal},
                    {24'd0, e.srcImm, e.srcPc, e.rw, e.mr, e.mw, e.br, e.jp, e.ill});
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = 32'h13; bus.in_pc = 32'd0;
        bus.rs1_data = 32'd0; bus.rs2_data = 32'd0;
        bus.wb_write = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        bus.out_ready = 1'b1; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_out_imm", bus.out_imm, 32'd0);
        @(posedge clk);
        #1;

        // addi x3,x0,7 held under backpressure for three cycles
        applyStimulus(32'h0070_0193, 32'h100, 32'h55, 32'h66, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("addi_rd", {27'd0, bus.out_rd}, 32'd3);
        checkOutput("addi_imm", bus.out_imm, 32'd7);
        checkOutput("addi_reg_write", {31'd0, bus.out_reg_write}, 32'd1);
        checkOutput("addi_src_imm", {31'd0, bus.out_alu_src_imm}, 32'd1);
        checkOutput("addi_rs1_val", bus.out_rs1_val, 32'd0);
        checkOutput("addi_alu_op", {28'd0, bus.out_alu_op}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0010_8093, 32'h104, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
            checkOutput("hold_pc", bus.out_pc, 32'h100);
            checkOutput("hold_imm", bus.out_imm, 32'd7);
        end
        applyStimulus(32'h0010_8093, 32'h104, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // reset while an instruction is held
        applyStimulus(32'h0070_0193, 32'h200, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midrst_out_imm", bus.out_imm, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sb.delete();
        mValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // bypass of a same-cycle writeback to rs1, then a writeback to x0
        applyStimulus(32'h0011_8213, 32'h300, 32'd0, 32'd0, 1'b1, 5'd3, 32'd7, 1'b1, 1'b1, 1'b0);
        checkOutput("bypass_hit", bus.out_rs1_val, BYP ? 32'd7 : 32'd0);
        applyStimulus(32'h0011_8213, 32'h304, 32'd0, 32'd0, 1'b1, 5'd0, 32'd7, 1'b1, 1'b1, 1'b0);
        checkOutput("bypass_x0", bus.out_rs1_val, 32'd0);

        // lw x5,0(x1) followed by dependent add x6,x5,x2
        applyStimulus(32'h0000_A283, 32'h400, 32'h10, 32'h20, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0022_8333, 32'h404, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("loaduse_bubble", {31'd0, bus.out_valid}, 32'd0);
        applyStimulus(32'h0022_8333, 32'h404, 32'h30, 32'h40, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("loaduse_issue", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("loaduse_rd", {27'd0, bus.out_rd}, 32'd6);

        // all-ones word is not a recognised opcode
        applyStimulus(32'hFFFF_FFFF, 32'h500, 32'h1, 32'h2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("illegal_flag", {31'd0, bus.out_illegal}, 32'd1);
        checkOutput("illegal_ctrl",
            {29'd0, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}, 32'd0);

        // randomized traffic with backpressure, flushes and writebacks
        for (int n = 0; n < 400; n++) begin
            applyStimulus(genInstr(), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, $urandom,
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 19) == 0));
        end

        repeat (3) idle(1'b1);
        checkOutput("sb_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
